div_sequencer: RTL

Multi-cycle 32-bit divide controller for the execute stage: it replaces the single-cycle `div`/`udiv` instances and the execute stage's shift-register delay with a real start/busy/done handshake. It latches operands, runs one restoring-division step per cycle, applies sign correction and holds the result until the write side takes it. Execute drives `start` for operations 6/7 and stalls its upstream on `busy`.

---
 rtl/div_sequencer_pkg.sv | 15 +
 rtl/div_sequencer_if.sv | 27 ++
 rtl/div_step.sv | 19 +
 rtl/div_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle divide controller.
package div_sequencer_pkg;
  localparam int DIV_XLEN       = 32;
  localparam int DIV_ITERATIONS = DIV_XLEN;

  typedef logic [DIV_XLEN-1:0] regval_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } div_state_t;
endpackage

// File: rtl/div_sequencer_if.sv
// Start/busy/done handshake between execute (master) and the divider (slave).
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_XLEN
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] numer;
  logic [WIDTH-1:0] denom;
  logic             hold;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divide_by_zero;

  modport master (
    output start, is_signed, numer, denom, hold,
    input  busy, done, quotient, remainder, divide_by_zero
  );

  modport slave (
    input  start, is_signed, numer, denom, hold,
    output busy, done, quotient, remainder, divide_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the dividend MSB, try to subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted  = {rem, dividend_msb};
  // rem < divisor holds every step, so the top bit of trial is a clean sign.
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divide controller: IDLE->PREP->ITER x WIDTH->FIXUP->DONE.
// Define DIV_EARLY_OUT_EN to finish from PREP on divide-by-zero or |numer| < |denom|.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_XLEN
) (
  input logic            clock,
  input logic            reset,
  div_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef logic [WIDTH-1:0] word_t;

  div_state_t    state, state_d;
  word_t         numer_q, denom_q;
  word_t         rem, dvd, dvs;
  logic [CW-1:0] cnt;
  logic          sgn_q, q_neg, r_neg, dz_q;
  word_t         quot_r, rem_r;
  logic          dz_r;

  word_t n_abs, d_abs, rem_nxt;
  logic  q_bit, d_zero, early, accept;

  assign n_abs  = (sgn_q && numer_q[WIDTH-1]) ? -numer_q : numer_q;
  assign d_abs  = (sgn_q && denom_q[WIDTH-1]) ? -denom_q : denom_q;
  assign d_zero = (denom_q == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = d_zero || (n_abs < d_abs);
`else
  assign early = 1'b0;
`endif

  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE && !bus.hold));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dvs),
    .rem_next     (rem_nxt),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (bus.start) state_d = S_PREP;
      S_PREP:  state_d = early ? S_DONE : S_ITER;
      S_ITER:  if (cnt == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (!bus.hold) state_d = bus.start ? S_PREP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      numer_q <= '0;
      denom_q <= '0;
      sgn_q   <= 1'b0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_q    <= 1'b0;
      quot_r  <= '0;
      rem_r   <= '0;
      dz_r    <= 1'b0;
    end else begin
      if (accept) begin
        numer_q <= bus.numer;
        denom_q <= bus.denom;
        sgn_q   <= bus.is_signed;
      end
      case (state)
        S_PREP: begin
          dvd   <= n_abs;
          dvs   <= d_abs;
          rem   <= '0;
          cnt   <= CW'(WIDTH-1);
          q_neg <= sgn_q & (numer_q[WIDTH-1] ^ denom_q[WIDTH-1]);
          r_neg <= sgn_q & numer_q[WIDTH-1];
          dz_q  <= d_zero;
          // Early exit: either the zero-divisor result or quotient 0 with the dividend as remainder.
          if (early) begin
            quot_r <= d_zero ? '1 : '0;
            rem_r  <= numer_q;
            dz_r   <= d_zero;
          end
        end
        S_ITER: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt - 1'b1;
        end
        S_FIXUP: begin
          if (dz_q) begin
            quot_r <= '1;
            rem_r  <= numer_q;
            dz_r   <= 1'b1;
          end else begin
            quot_r <= q_neg ? -dvd : dvd;
            rem_r  <= r_neg ? -rem : rem;
            dz_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state == S_PREP) || (state == S_ITER) || (state == S_FIXUP);
  assign bus.done           = (state == S_DONE);
  assign bus.quotient       = quot_r;
  assign bus.remainder      = rem_r;
  assign bus.divide_by_zero = dz_r;
endmodule
